iob_eth_rx_frame_wr: RTL and testbench

MII receive-side frame writer for the Ethernet core. It samples the 4-bit MII receive stream and strips the preamble/SFD. It filters on destination MAC (own address or broadcast), assembles nibbles into bytes, and writes the frame bytes into the write port of the dual-port receive buffer RAM, starting at address 0. It then holds the frame length and a ready flag until the host acknowledges, and counts dropped frames.

---
 rtl/iob_eth_rx_pkg.sv | 21 ++
 rtl/iob_eth_rx_mac_filter.sv | 48 ++++
 rtl/iob_eth_rx_frame_wr.sv | 135 +++++++++++++
 tb/tb_iob_eth_rx_frame_wr.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_rx_pkg.sv
// rtl/iob_eth_rx_pkg.sv - shared state encoding and constants for the MII receive frame writer
package iob_eth_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_DONE     = 3'd3,
        ST_DROP     = 3'd4
    } rx_state_t;

    localparam logic [3:0] PREAMBLE_NIB  = 4'h5;
    localparam logic [3:0] SFD_NIB       = 4'hD;
    localparam logic [7:0] BCAST_BYTE    = 8'hFF;
    localparam int         MAC_HDR_BYTES = 6;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/iob_eth_rx_mac_filter.sv
// rtl/iob_eth_rx_mac_filter.sv - sticky destination-address mismatch flags for own and broadcast MAC
module iob_eth_rx_mac_filter
    import iob_eth_rx_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h0000_0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       byte_stb,
    input  logic [2:0] byte_idx,
    input  logic [7:0] byte_data,
    output logic       own_mismatch,
    output logic       bcast_mismatch
);

    logic [7:0] mac_byte;
    logic       own_q;
    logic       bcast_q;

    always_comb begin
        mac_byte = 8'h00;
        case (byte_idx)
            3'd0:    mac_byte = MAC_ADDR[47:40];
            3'd1:    mac_byte = MAC_ADDR[39:32];
            3'd2:    mac_byte = MAC_ADDR[31:24];
            3'd3:    mac_byte = MAC_ADDR[23:16];
            3'd4:    mac_byte = MAC_ADDR[15:8];
            3'd5:    mac_byte = MAC_ADDR[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    // Flags include the byte being strobed so the top can decide on byte 5 in the same cycle.
    assign own_mismatch   = own_q   | (byte_stb & (byte_data != mac_byte));
    assign bcast_mismatch = bcast_q | (byte_stb & (byte_data != BCAST_BYTE));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            own_q   <= 1'b0;
            bcast_q <= 1'b0;
        end else if (byte_stb) begin
            own_q   <= own_mismatch;
            bcast_q <= bcast_mismatch;
        end
    end

endmodule

// File: rtl/iob_eth_rx_frame_wr.sv
// rtl/iob_eth_rx_frame_wr.sv - MII receive frame writer into the receive buffer RAM write port
module iob_eth_rx_frame_wr
    import iob_eth_rx_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter int          ADDR_W   = 11,
    parameter logic [47:0] MAC_ADDR = 48'h0000_0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_dv,
    input  logic [3:0]        rxd,
    input  logic              rcv_ack,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data,
    output logic              buf_we,
    output logic              rx_ready,
    output logic [ADDR_W:0]   rx_nbytes,
    output logic [7:0]        rx_drop_cnt
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] HDR_CNT  = (ADDR_W+1)'(MAC_HDR_BYTES);
    localparam logic [ADDR_W:0] LAST_HDR = (ADDR_W+1)'(MAC_HDR_BYTES - 1);

    rx_state_t       state;
    logic            phase;
    logic [3:0]      low_nib;
    logic [ADDR_W:0] count;
    logic [7:0]      rx_byte;
    logic            filt_clear;
    logic            byte_stb;
    logic            own_mm;
    logic            bcast_mm;

    assign rx_byte    = {rxd, low_nib};
    assign filt_clear = (state == ST_PREAMBLE) && rx_dv && (rxd == SFD_NIB);
    assign byte_stb   = (state == ST_DATA) && rx_dv && phase && (count < HDR_CNT);

    iob_eth_rx_mac_filter #(
        .MAC_ADDR(MAC_ADDR)
    ) u_mac_filter (
        .clk           (clk),
        .rst           (rst),
        .clear         (filt_clear),
        .byte_stb      (byte_stb),
        .byte_idx      (count[2:0]),
        .byte_data     (rx_byte),
        .own_mismatch  (own_mm),
        .bcast_mismatch(bcast_mm)
    );

    // Reset lands in DROP so a frame already on the wire is skipped rather than captured mid-stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_DROP;
            phase       <= 1'b0;
            low_nib     <= 4'h0;
            count       <= '0;
            buf_addr    <= '0;
            buf_data    <= '0;
            buf_we      <= 1'b0;
            rx_ready    <= 1'b0;
            rx_nbytes   <= '0;
            rx_drop_cnt <= 8'h00;
        end else begin
            buf_we <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rx_dv) begin
                        if (rxd == PREAMBLE_NIB) begin
                            state <= ST_PREAMBLE;
                        end else begin
                            state       <= ST_DROP;
                            rx_drop_cnt <= sat_inc8(rx_drop_cnt);
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (rx_dv && (rxd == SFD_NIB)) begin
                        state <= ST_DATA;
                        phase <= 1'b0;
                        count <= '0;
                    end else if (!(rx_dv && (rxd == PREAMBLE_NIB))) begin
                        state       <= ST_DROP;
                        rx_drop_cnt <= sat_inc8(rx_drop_cnt);
                    end
                end
                ST_DATA: begin
                    if (!rx_dv) begin
                        if (phase || (count < HDR_CNT)) begin
                            state       <= ST_DROP;
                            rx_drop_cnt <= sat_inc8(rx_drop_cnt);
                        end else begin
                            rx_nbytes <= count;
                            rx_ready  <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end else if (!phase) begin
                        if (count == CAPACITY) begin
                            state       <= ST_DROP;
                            rx_drop_cnt <= sat_inc8(rx_drop_cnt);
                        end else begin
                            low_nib <= rxd;
                            phase   <= 1'b1;
                        end
                    end else begin
                        buf_we   <= 1'b1;
                        buf_addr <= count[ADDR_W-1:0];
                        buf_data <= DATA_W'(rx_byte);
                        count    <= count + 1'b1;
                        phase    <= 1'b0;
                        if ((count == LAST_HDR) && own_mm && bcast_mm) begin
                            state       <= ST_DROP;
                            rx_drop_cnt <= sat_inc8(rx_drop_cnt);
                        end
                    end
                end
                ST_DONE: begin
                    if (rcv_ack) begin
                        rx_ready <= 1'b0;
                        state    <= rx_dv ? ST_DROP : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!rx_dv) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_DROP;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_rx_frame_wr.sv
// tb/tb_iob_eth_rx_frame_wr.sv - randomized scoreboard bench for iob_eth_rx_frame_wr (two buffer sizes)
module tb_iob_eth_rx_frame_wr;

    localparam logic [47:0] MAC = 48'h0200_0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic        rcv_ack = 1'b0;
    logic [3:0]  rxd = 4'h0;

    logic [10:0] a_addr;
    logic [7:0]  a_data;
    logic        a_we;
    logic        a_ready;
    logic [11:0] a_nbytes;
    logic [7:0]  a_drop;
    logic [3:0]  b_addr;
    logic [7:0]  b_data;
    logic        b_we;
    logic        b_ready;
    logic [4:0]  b_nbytes;
    logic [7:0]  b_drop;

    int checks = 0;
    int failures = 0;
    int m_ready[2];
    int m_nbytes[2];
    int m_drop[2];
    int cap[2];
    int exp_q0[$];
    int exp_q1[$];
    logic [3:0]  fr[$];
    logic [47:0] mac_v;

    iob_eth_rx_frame_wr #(.DATA_W(8), .ADDR_W(11), .MAC_ADDR(MAC)) dut_a (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rxd(rxd), .rcv_ack(rcv_ack),
        .buf_addr(a_addr), .buf_data(a_data), .buf_we(a_we),
        .rx_ready(a_ready), .rx_nbytes(a_nbytes), .rx_drop_cnt(a_drop)
    );

    iob_eth_rx_frame_wr #(.DATA_W(8), .ADDR_W(4), .MAC_ADDR(MAC)) dut_b (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rxd(rxd), .rcv_ack(rcv_ack),
        .buf_addr(b_addr), .buf_data(b_data), .buf_we(b_we),
        .rx_ready(b_ready), .rx_nbytes(b_nbytes), .rx_drop_cnt(b_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_wr(input int i, input int a, input int d);
        if (i == 0) exp_q0.push_back(a * 256 + d);
        else        exp_q1.push_back(a * 256 + d);
    endtask

    task automatic pop_check(input int i, input int a, input int d);
        int e;
        checks++;
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            failures++;
            $display("FAIL wr%0d_unexpected actual=addr %0d data %02h expected=no write", i, a, d);
        end else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (a * 256 + d != e) begin
                failures++;
                $display("FAIL wr%0d actual=addr %0d data %02h expected=addr %0d data %02h",
                         i, a, d, e / 256, e % 256);
            end
        end
    endtask

    always @(negedge clk) begin
        if (a_we) pop_check(0, int'(a_addr), int'(a_data));
        if (b_we) pop_check(1, int'(b_addr), int'(b_data));
    end

    task automatic model_drop(input int i);
        m_drop[i] = (m_drop[i] < 255) ? m_drop[i] + 1 : 255;
    endtask

    // Frame-level reference: decides the fate of a whole nibble stream for one buffer size.
    task automatic model_frame(input int i, input int ack_at);
        int p, n, nb, w;
        bit own_mm, bc_mm, filt;
        logic [7:0] b;
        if (m_ready[i] != 0) begin
            if (ack_at >= 0) m_ready[i] = 0;
            return;
        end
        if (fr.size() == 0) return;
        if (fr[0] != 4'h5) begin model_drop(i); return; end
        p = 1;
        while (p < fr.size() && fr[p] == 4'h5) p++;
        if (p >= fr.size() || fr[p] != 4'hD) begin model_drop(i); return; end
        p++;
        n = fr.size() - p;
        nb = n / 2;
        own_mm = 0;
        bc_mm = 0;
        for (int j = 0; j < 6 && j < nb; j++) begin
            b = {fr[p+2*j+1], fr[p+2*j]};
            if (b != mac_v[47-8*j -: 8]) own_mm = 1;
            if (b != 8'hFF) bc_mm = 1;
        end
        filt = (nb >= 6) && own_mm && bc_mm;
        if (filt) w = 6;
        else if (n > 2 * cap[i]) w = cap[i];
        else w = nb;
        for (int k = 0; k < w; k++) push_wr(i, k, int'({fr[p+2*k+1], fr[p+2*k]}));
        if (filt || n > 2 * cap[i] || (n % 2) != 0 || nb < 6) model_drop(i);
        else begin
            m_ready[i] = 1;
            m_nbytes[i] = nb;
        end
    endtask

    task automatic make_frame(input int pre, input logic [47:0] dst, input int nbytes, input bit odd);
        logic [7:0] b;
        fr.delete();
        repeat (pre) fr.push_back(4'h5);
        fr.push_back(4'hD);
        for (int j = 0; j < nbytes; j++) begin
            b = (j < 6) ? dst[47-8*j -: 8] : 8'($urandom);
            fr.push_back(b[3:0]);
            fr.push_back(b[7:4]);
        end
        if (odd) fr.push_back(4'($urandom));
    endtask

    task automatic check_status(input string tag);
        check({tag, "_rdy_a"}, int'(a_ready), m_ready[0]);
        check({tag, "_nb_a"}, int'(a_nbytes), m_nbytes[0]);
        check({tag, "_drop_a"}, int'(a_drop), m_drop[0]);
        check({tag, "_wrq_a"}, exp_q0.size(), 0);
        check({tag, "_rdy_b"}, int'(b_ready), m_ready[1]);
        check({tag, "_nb_b"}, int'(b_nbytes), m_nbytes[1]);
        check({tag, "_drop_b"}, int'(b_drop), m_drop[1]);
        check({tag, "_wrq_b"}, exp_q1.size(), 0);
    endtask

    task automatic send_frame(input string tag, input int ack_at, input int gap);
        model_frame(0, ack_at);
        model_frame(1, ack_at);
        for (int k = 0; k < fr.size(); k++) begin
            @(posedge clk); #1;
            rx_dv = 1'b1;
            rxd = fr[k];
            rcv_ack = (k == ack_at);
        end
        @(posedge clk); #1;
        rx_dv = 1'b0;
        rcv_ack = 1'b0;
        rxd = 4'($urandom);
        @(posedge clk); #1;
        check_status(tag);
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic send_ack(input string tag);
        @(posedge clk); #1;
        rcv_ack = 1'b1;
        @(posedge clk); #1;
        rcv_ack = 1'b0;
        m_ready[0] = 0;
        m_ready[1] = 0;
        check_status(tag);
    endtask

    initial begin
        int kind, nbytes, ack_at, rst_at;
        logic [47:0] dst;
        mac_v = MAC;
        cap[0] = 2048;
        cap[1] = 16;
        for (int i = 0; i < 2; i++) begin
            m_ready[i] = 0; m_nbytes[i] = 0; m_drop[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_we_a", int'(a_we), 0);
        check("reset_addr_a", int'(a_addr), 0);
        check("reset_data_a", int'(a_data), 0);
        check_status("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        make_frame(15, MAC, 60, 0);
        send_frame("own60", -1, 3);
        repeat (10) @(posedge clk);
        #1;
        check_status("own60_hold");
        send_ack("own60_ack");

        make_frame(15, 48'hFFFF_FFFF_FFFF, 64, 0);
        send_frame("bcast64", -1, 2);
        send_ack("bcast64_ack");

        make_frame(15, 48'h0200_0000_0002, 60, 0);
        send_frame("foreign", -1, 2);

        make_frame(15, MAC, 20, 0);
        fr[6] = 4'h7;
        send_frame("bad_pre", -1, 2);

        make_frame(15, MAC, 60, 1);
        send_frame("odd121", -1, 2);

        make_frame(15, MAC, 4, 0);
        send_frame("runt4", -1, 2);

        make_frame(7, MAC, 12, 0);
        send_frame("small12", -1, 2);
        make_frame(9, MAC, 30, 0);
        send_frame("while_ready", -1, 2);
        make_frame(9, MAC, 30, 0);
        send_frame("ack_mid", 20, 2);
        make_frame(15, MAC, 40, 0);
        send_frame("after_ack", -1, 2);
        send_ack("after_ack_ack");

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) dst = MAC;
            else if (kind < 6) dst = 48'hFFFF_FFFF_FFFF;
            else if (kind < 8) dst = {8'h02, 32'h0, 8'($urandom_range(2, 254))};
            else dst = {8'hFF, MAC[39:0]};
            nbytes = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 20) : $urandom_range(21, 90);
            make_frame($urandom_range(1, 15), dst, nbytes, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) fr[$urandom_range(0, 1)] = 4'h7;
            ack_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, fr.size() - 1) : -1;
            send_frame($sformatf("rnd%0d", it), ack_at, $urandom_range(1, 4));
            if ($urandom_range(0, 1) != 0) send_ack($sformatf("rnd%0d_ack", it));
        end

        send_ack("pre_rst");
        make_frame(15, MAC, 60, 0);
        rst_at = 16 + 20;
        for (int k = 0; k < 10; k++) begin
            push_wr(0, k, int'({fr[16+2*k+1], fr[16+2*k]}));
            push_wr(1, k, int'({fr[16+2*k+1], fr[16+2*k]}));
        end
        for (int k = 0; k < fr.size(); k++) begin
            @(posedge clk); #1;
            if (k == rst_at + 1) begin
                for (int i = 0; i < 2; i++) begin
                    m_ready[i] = 0; m_nbytes[i] = 0; m_drop[i] = 0;
                end
                check("midrst_we_a", int'(a_we), 0);
                check("midrst_addr_a", int'(a_addr), 0);
                check("midrst_data_a", int'(a_data), 0);
                check("midrst_we_b", int'(b_we), 0);
                check_status("midrst");
            end
            rx_dv = 1'b1;
            rxd = fr[k];
            rst = (k == rst_at);
        end
        @(posedge clk); #1;
        rx_dv = 1'b0;
        @(posedge clk); #1;
        check_status("midrst_end");
        repeat (2) @(posedge clk);
        #1;
        make_frame(15, MAC, 10, 0);
        send_frame("post_rst", -1, 2);
        send_ack("post_rst_ack");

        for (int k = 0; k < 256; k++) begin
            fr.delete();
            fr.push_back(4'h7);
            send_frame("sat", -1, 1);
        end
        check("sat_final_a", int'(a_drop), 255);

        repeat (4) @(posedge clk);
        #1;
        check("final_wrq_a", exp_q0.size(), 0);
        check("final_wrq_b", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
